// File: rtl/sccb_target_model.sv
// SCCB camera-side responder: oversamples SIOC/SIOD, decodes ID/sub-address/data phases,
// keeps a 256x8 register file and drives SIOD open-drain for ACK and read data.
module sccb_target_model #(
    parameter logic [7:0] DEV_ID  = 8'h60,
    parameter bit         ACK_EN  = 1'b1,
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sioc,
    input  logic       siod_i,
    output logic       siod_oe,
    output logic       wr_valid,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_DEV  = 3'd1;
    localparam logic [2:0] S_SUB  = 3'd2;
    localparam logic [2:0] S_WDAT = 3'd3;
    localparam logic [2:0] S_RDAT = 3'd4;
    localparam logic [2:0] S_SKIP = 3'd5;

    // [0],[1] synchronizer, [2] previous value; no reset so a reset never fakes a bus edge
    logic [2:0] scl_q, sda_q;
    always_ff @(posedge clk) begin
        scl_q <= {scl_q[1:0], sioc};
        sda_q <= {sda_q[1:0], siod_i};
    end

    logic scl, sda, scl_rise, scl_fall, scl_hold, start, stop;
    assign scl      = scl_q[1];
    assign sda      = sda_q[1];
    assign scl_rise = scl & ~scl_q[2];
    assign scl_fall = ~scl & scl_q[2];
    // START/STOP only when SIOC is stably high, so a coincident SIOC edge wins
    assign scl_hold = scl & scl_q[2];
    assign start    = scl_hold & ~sda & sda_q[2];
    assign stop     = scl_hold & sda & ~sda_q[2];

    logic [2:0] state_q;
    logic [2:0] cnt_q;
    logic       ninth_q;
    logic       ack_q;
    logic       rdb_q;
    logic [6:0] rx_q;
    logic [7:0] tx_q;
    logic [7:0] ptr_q;
    logic [7:0] mem_q [256];

    logic [7:0] byte_d;
    logic       active, byte_done, mem_we;
    assign byte_d    = {rx_q, sda};
    assign active    = (state_q == S_DEV) || (state_q == S_SUB) ||
                       (state_q == S_WDAT) || (state_q == S_RDAT);
    assign byte_done = active & scl_rise & ~ninth_q & (cnt_q == 3'd7);
    assign mem_we    = byte_done & (state_q == S_WDAT);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem_q[i] <= RST_VAL;
        end else if (mem_we) begin
            mem_q[ptr_q] <= byte_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 3'd0;
            ninth_q  <= 1'b0;
            ack_q    <= 1'b0;
            rdb_q    <= 1'b0;
            rx_q     <= 7'd0;
            tx_q     <= 8'd0;
            ptr_q    <= 8'd0;
            siod_oe  <= 1'b0;
            wr_valid <= 1'b0;
            wr_addr  <= 8'd0;
            wr_data  <= 8'd0;
            busy     <= 1'b0;
        end else begin
            wr_valid <= 1'b0;
            if (start) begin
                state_q <= S_DEV;
                cnt_q   <= 3'd0;
                ninth_q <= 1'b0;
                ack_q   <= 1'b0;
                rdb_q   <= 1'b0;
                siod_oe <= 1'b0;
                busy    <= 1'b1;
            end else if (stop) begin
                state_q <= S_IDLE;
                cnt_q   <= 3'd0;
                ninth_q <= 1'b0;
                ack_q   <= 1'b0;
                rdb_q   <= 1'b0;
                siod_oe <= 1'b0;
                busy    <= 1'b0;
            end else if (active && scl_rise) begin
                if (ninth_q) begin
                    ninth_q <= 1'b0;
                    // master's ACK/NA after a byte we sent
                    if (rdb_q) begin
                        rdb_q <= 1'b0;
                        ptr_q <= ptr_q + 8'd1;
                        if (sda) state_q <= S_SKIP;
                        else     tx_q    <= mem_q[ptr_q + 8'd1];
                    end
                end else begin
                    rx_q  <= byte_d[6:0];
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        ninth_q <= 1'b1;
                        ack_q   <= ACK_EN;
                        case (state_q)
                            S_DEV: begin
                                if (byte_d[7:1] != DEV_ID[7:1]) begin
                                    state_q <= S_SKIP;
                                    ack_q   <= 1'b0;
                                end else if (byte_d[0]) begin
                                    state_q <= S_RDAT;
                                    tx_q    <= mem_q[ptr_q];
                                end else begin
                                    state_q <= S_SUB;
                                end
                            end
                            S_SUB: begin
                                ptr_q   <= byte_d;
                                state_q <= S_WDAT;
                            end
                            S_WDAT: begin
                                ptr_q    <= ptr_q + 8'd1;
                                wr_valid <= 1'b1;
                                wr_addr  <= ptr_q;
                                wr_data  <= byte_d;
                            end
                            default: begin
                                ack_q <= 1'b0;
                                rdb_q <= 1'b1;
                            end
                        endcase
                    end
                end
            end else if (active && scl_fall) begin
                if (ninth_q) begin
                    siod_oe <= ack_q;
                end else if (state_q == S_RDAT) begin
                    siod_oe <= ~tx_q[7];
                    tx_q    <= {tx_q[6:0], 1'b0};
                end else begin
                    siod_oe <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_sccb_target_model.sv
// Bench for sccb_target_model: bit-banged SCCB master, table of 3-phase writes,
// hand-written corner sequences and random transactions against a register-file model.
module tb_sccb_target_model;
    localparam int Q = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sioc = 1'b1;
    logic       sda_m = 1'b1;
    logic       siod_bus, siod_oe, wr_valid, busy;
    logic [7:0] wr_addr, wr_data;

    assign siod_bus = sda_m & ~siod_oe;
    always #5 clk = ~clk;

    sccb_target_model dut (
        .clk(clk), .rst(rst), .sioc(sioc), .siod_i(siod_bus), .siod_oe(siod_oe),
        .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy)
    );

    int total = 0;
    int bad = 0;

    logic [15:0] plog [0:1023];
    logic [9:0]  pcnt = '0;
    int          oecnt = 0;
    always @(negedge clk) begin
        if (wr_valid === 1'b1) begin
            plog[pcnt] = {wr_addr, wr_data};
            pcnt = pcnt + 10'd1;
        end
        if (siod_oe === 1'b1) oecnt = oecnt + 1;
    end

    // register-file model
    logic [7:0]  mmem [0:255];
    logic [7:0]  mptr;
    logic [15:0] ep [0:3];
    int          en;
    logic [4:0]  eack;

    // observations of the last transaction
    logic [9:0]  pbase;
    int          oebase;
    int          gnp;
    logic [4:0]  gack;
    logic [7:0]  glast;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_cyc(input logic b, output logic bus_s, output logic oe_s);
        sioc = 1'b0; clk_n(Q);
        sda_m = b;   clk_n(Q);
        sioc = 1'b1; clk_n(Q);
        bus_s = siod_bus; oe_s = siod_oe;
        clk_n(Q);
    endtask

    task automatic bus_start();
        sioc = 1'b0;  clk_n(Q);
        sda_m = 1'b1; clk_n(Q);
        sioc = 1'b1;  clk_n(2*Q);
        sda_m = 1'b0; clk_n(2*Q);
    endtask

    task automatic bus_stop();
        sioc = 1'b0;  clk_n(Q);
        sda_m = 1'b0; clk_n(Q);
        sioc = 1'b1;  clk_n(2*Q);
        sda_m = 1'b1; clk_n(2*Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic bs, os;
        for (int i = 7; i >= 0; i--) bit_cyc(b[i], bs, os);
        bit_cyc(1'b1, bs, os);
        ack = os;
    endtask

    task automatic recv_byte(input logic nack, output logic [7:0] v);
        logic bs, os;
        for (int i = 7; i >= 0; i--) begin
            bit_cyc(1'b1, bs, os);
            v[i] = bs;
        end
        bit_cyc(nack, bs, os);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) mmem[i] = 8'h00;
        mptr = 8'h00;
    endtask

    task automatic model_write(input logic [7:0] id, input int n,
                               input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        logic [7:0] d [3];
        d = '{d0, d1, d2};
        en = 0;
        eack = '0;
        if (id[7:1] == 7'h30 && id[0] == 1'b0) begin
            eack = 5'((1 << (n + 1)) - 1);
            mptr = d[0];
            for (int i = 1; i < n; i++) begin
                ep[en] = {mptr, d[i]};
                en++;
                mmem[mptr] = d[i];
                mptr = mptr + 8'd1;
            end
        end
    endtask

    task automatic run_write(input logic [7:0] id, input int n,
                             input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        logic [7:0] d [3];
        logic a;
        d = '{d0, d1, d2};
        pbase = pcnt;
        oebase = oecnt;
        gack = '0;
        bus_start();
        send_byte(id, a);
        gack = {gack[3:0], a};
        for (int i = 0; i < n; i++) begin
            send_byte(d[i], a);
            gack = {gack[3:0], a};
        end
        bus_stop();
        clk_n(3);
        gnp = int'(10'(pcnt - pbase));
        model_write(id, n, d0, d1, d2);
    endtask

    task automatic check_write(input string nm);
        chk({nm, ".ack"}, 32'(gack), 32'(eack));
        chk({nm, ".npulse"}, gnp, en);
        for (int i = 0; i < en && i < gnp; i++)
            chk({nm, ".pulse"}, 32'(plog[10'(pbase + 10'(i))]), 32'(ep[i]));
    endtask

    task automatic run_read(input string nm, input int n);
        logic a;
        logic [7:0] v;
        bus_start();
        send_byte(8'h61, a);
        chk({nm, ".idack"}, 32'(a), 32'd1);
        for (int i = 0; i < n; i++) begin
            recv_byte(i == n - 1, v);
            chk({nm, ".rdata"}, 32'(v), 32'(mmem[mptr]));
            mptr = mptr + 8'd1;
            glast = v;
        end
        bus_stop();
        clk_n(3);
    endtask

    typedef struct {
        logic [7:0] id;
        logic [7:0] sub;
        logic [7:0] dat;
        int         np;
        logic [7:0] pa;
        logic [7:0] pd;
        logic [2:0] ack;
    } vec_t;

    initial begin
        vec_t tbl [6];
        logic a, bs, os;
        logic [7:0] sb;
        tbl[0] = '{8'h60, 8'h12, 8'h80, 1, 8'h12, 8'h80, 3'b111};
        tbl[1] = '{8'h42, 8'h33, 8'h44, 0, 8'h00, 8'h00, 3'b000};
        tbl[2] = '{8'h60, 8'hFF, 8'h11, 1, 8'hFF, 8'h11, 3'b111};
        tbl[3] = '{8'hC0, 8'h01, 8'h02, 0, 8'h00, 8'h00, 3'b000};
        tbl[4] = '{8'h60, 8'h00, 8'h5A, 1, 8'h00, 8'h5A, 3'b111};
        tbl[5] = '{8'h62, 8'h10, 8'h20, 0, 8'h00, 8'h00, 3'b000};

        model_reset();
        clk_n(5);
        rst = 1'b0;
        clk_n(1);
        chk("rst.oe", 32'(siod_oe), 32'd0);
        chk("rst.wr_valid", 32'(wr_valid), 32'd0);
        chk("rst.wr_addr", 32'(wr_addr), 32'd0);
        chk("rst.wr_data", 32'(wr_data), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);

        // 2-phase write then read of an untouched register
        run_write(8'h60, 1, 8'h0A, 8'h00, 8'h00);
        check_write("t3.w");
        run_read("t3.r", 1);
        chk("t3.rstval", 32'(glast), 32'h00);

        for (int i = 0; i < 6; i++) begin
            run_write(tbl[i].id, 2, tbl[i].sub, tbl[i].dat, 8'h00);
            chk("tbl.ack", 32'(gack), 32'(tbl[i].ack));
            chk("tbl.npulse", gnp, tbl[i].np);
            if (gnp > 0 && tbl[i].np > 0)
                chk("tbl.pulse", 32'(plog[pbase]), 32'({tbl[i].pa, tbl[i].pd}));
        end
        run_write(8'h60, 1, 8'h12, 8'h00, 8'h00);
        run_read("t1.r", 1);
        chk("t1.mem12", 32'(glast), 32'h80);

        // burst write with auto-increment
        run_write(8'h60, 2, 8'h44, 8'h3C, 8'h00);
        run_write(8'h60, 3, 8'h42, 8'hA5, 8'hA6);
        check_write("t2.w");
        chk("t2.np", gnp, 2);
        chk("t2.p0", 32'(plog[pbase]), 32'h42A5);
        chk("t2.p1", 32'(plog[10'(pbase + 10'd1)]), 32'h43A6);
        run_read("t2.r", 1);
        chk("t2.ptr44", 32'(glast), 32'h3C);

        // foreign ID: silent but busy until STOP
        pbase = pcnt;
        oebase = oecnt;
        bus_start();
        send_byte(8'h42, a);
        chk("t4.busy0", 32'(busy), 32'd1);
        send_byte(8'h33, a);
        send_byte(8'h44, a);
        chk("t4.busy1", 32'(busy), 32'd1);
        bus_stop();
        clk_n(3);
        chk("t4.busy_end", 32'(busy), 32'd0);
        chk("t4.oe_hits", oecnt - oebase, 0);
        chk("t4.npulse", int'(10'(pcnt - pbase)), 0);

        // STOP in the middle of a data byte
        pbase = pcnt;
        bus_start();
        send_byte(8'h60, a);
        send_byte(8'h20, a);
        for (int i = 0; i < 5; i++) bit_cyc(1'($urandom_range(0, 1)), bs, os);
        bus_stop();
        clk_n(3);
        mptr = 8'h20;
        chk("t5.npulse", int'(10'(pcnt - pbase)), 0);
        chk("t5.busy", 32'(busy), 32'd0);
        run_write(8'h60, 2, 8'hFF, 8'h11, 8'h00);
        check_write("t5.w");
        chk("t5.pulse", 32'(plog[pbase]), 32'hFF11);
        run_read("t5.r", 1);
        chk("t5.wrap", 32'(glast), 32'h5A);

        // reset while the sub-address ACK is being driven
        bus_start();
        send_byte(8'h60, a);
        sb = 8'h21;
        for (int i = 7; i >= 0; i--) bit_cyc(sb[i], bs, os);
        sda_m = 1'b1;
        sioc = 1'b0;
        clk_n(5);
        chk("t6.ack_on", 32'(siod_oe), 32'd1);
        rst = 1'b1;
        clk_n(1);
        chk("t6.released", 32'(siod_oe), 32'd0);
        chk("t6.busy", 32'(busy), 32'd0);
        rst = 1'b0;
        bus_stop();
        clk_n(3);
        model_reset();
        run_write(8'h60, 2, 8'h21, 8'h77, 8'h00);
        check_write("t6.w");
        chk("t6.pulse", 32'(plog[pbase]), 32'h2177);
        run_read("t6.r", 1);

        for (int it = 0; it < 30; it++) begin
            if ($urandom_range(0, 3) == 0) begin
                run_read("rnd.r", int'($urandom_range(1, 3)));
            end else begin
                logic [7:0] id;
                logic [6:0] hi;
                id = 8'h60;
                if ($urandom_range(0, 4) == 0) begin
                    hi = 7'($urandom_range(0, 127));
                    if (hi == 7'h30) hi = 7'h31;
                    id = {hi, 1'b0};
                end
                run_write(id, int'($urandom_range(1, 3)), 8'($urandom), 8'($urandom), 8'($urandom));
                check_write("rnd.w");
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
